mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/riscv_pkg.sv | 16 +
 rtl/wait_timer.sv | 29 ++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: memory arbiter state encoding,
// grant identifiers and default bus timeout.
package riscv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int ARB_TIMEOUT_CYC = 15;

endpackage

// File: rtl/wait_timer.sv
// Busy-cycle counter: expired flags the LIMIT-th enabled cycle
// since the last clear.
module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = enable && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/load-store arbiter onto one single-port memory,
// one transaction in flight, with bus timeout.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [31:0]       instr_rdata,
  output logic              instr_ready,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err,
  output logic              stall_f,
  output logic              stall_m
);

  arb_state_e        r_state;
  logic              r_gnt;
  logic              r_last;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_instr_rdata;
  logic [31:0]       r_data_rdata;
  logic              r_instr_ready;
  logic              r_data_ready;
  logic              r_bus_err;

  logic        w_pick;
  logic        w_tmr_clr;
  logic        w_tmr_en;
  logic        w_tmr_exp;
  logic        w_fin;
  logic        w_is_rd;
  logic [31:0] w_cap;

  // On a tie the port that lost the previous arbitration wins.
  always_comb begin
    w_pick = GRANT_I;
    if (instr_req && data_req) begin
      w_pick = ~r_last;
    end else if (data_req) begin
      w_pick = GRANT_D;
    end
  end

  assign w_tmr_en  = (r_state == ARB_BUSY);
  assign w_tmr_clr = (r_state != ARB_BUSY);
  assign w_fin     = mem_ready || w_tmr_exp;
  assign w_is_rd   = (r_gnt == GRANT_I) || !r_mem_we;
  assign w_cap     = mem_ready ? mem_rdata : 32'h0;

  wait_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_tmr_clr),
    .enable  (w_tmr_en),
    .expired (w_tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ARB_IDLE;
      r_gnt         <= GRANT_I;
      r_last        <= GRANT_I;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_instr_rdata <= '0;
      r_data_rdata  <= '0;
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      r_bus_err     <= 1'b0;
    end else begin
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      r_bus_err     <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (instr_req || data_req) begin
            r_gnt     <= w_pick;
            r_last    <= w_pick;
            r_mem_req <= 1'b1;
            r_state   <= ARB_BUSY;
            if (w_pick == GRANT_D) begin
              r_mem_we    <= data_we;
              r_mem_addr  <= data_addr;
              r_mem_wdata <= data_wdata;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= instr_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        ARB_BUSY: begin
          if (w_fin) begin
            r_mem_req     <= 1'b0;
            r_instr_ready <= (r_gnt == GRANT_I);
            r_data_ready  <= (r_gnt == GRANT_D);
            r_bus_err     <= !mem_ready;
            r_state       <= ARB_DONE;
            // Stores never touch the load data register.
            if (w_is_rd) begin
              if (r_gnt == GRANT_I) begin
                r_instr_rdata <= w_cap;
              end else begin
                r_data_rdata <= w_cap;
              end
            end
          end
        end
        ARB_DONE: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign instr_rdata = r_instr_rdata;
  assign instr_ready = r_instr_ready;
  assign data_rdata  = r_data_rdata;
  assign data_ready  = r_data_ready;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign bus_err     = r_bus_err;
  assign stall_f     = instr_req & ~r_instr_ready;
  assign stall_m     = data_req & ~r_data_ready;

endmodule
